// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared decode/execute types: ALU op, control bundle, NOP bundle
package rv32i_pkg;

    localparam int DPW_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic    regwrite;
        logic    load;
        logic    memwrite;
        logic    branch;
        logic    alusrc;
        logic    use_rs1;
        logic    use_rs2;
        alu_op_t alu_ctrl;
    } ctrl_t;

    // Bubble / flushed slot: no side effects, ALU op fixed to ADD.
    localparam ctrl_t CTRL_NOP = '{
        regwrite: 1'b0,
        load:     1'b0,
        memwrite: 1'b0,
        branch:   1'b0,
        alusrc:   1'b0,
        use_rs1:  1'b0,
        use_rs2:  1'b0,
        alu_ctrl: ALU_ADD
    };

endpackage

// File: rtl/rf_bypass.sv
// rtl/rf_bypass.sv - NREG x DPW register file, x0 hardwired, optional write-through
//
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears every entry)
//   we_i/waddr_i/wdata_i write port, committed at posedge
//   raddr_a_i/rdata_a_o  combinational read port A
//   raddr_b_i/rdata_b_o  combinational read port B
module rf_bypass #(
    parameter int  DPW    = 32,
    parameter int  NREG   = 32,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we_i,
    input  logic [AW-1:0]  waddr_i,
    input  logic [DPW-1:0] wdata_i,
    input  logic [AW-1:0]  raddr_a_i,
    input  logic [AW-1:0]  raddr_b_i,
    output logic [DPW-1:0] rdata_a_o,
    output logic [DPW-1:0] rdata_b_o
);

    logic [DPW-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // A nonzero read address equal to the write address implies the write
    // targets a real register, so no separate x0 test on the write side.
    always_comb begin
        rdata_a_o = '0;
        if (raddr_a_i != '0) begin
            if ((BYPASS != 0) && we_i && (raddr_a_i == waddr_i)) begin
                rdata_a_o = wdata_i;
            end else begin
                rdata_a_o = regs_q[raddr_a_i];
            end
        end
    end

    always_comb begin
        rdata_b_o = '0;
        if (raddr_b_i != '0) begin
            if ((BYPASS != 0) && we_i && (raddr_b_i == waddr_i)) begin
                rdata_b_o = wdata_i;
            end else begin
                rdata_b_o = regs_q[raddr_b_i];
            end
        end
    end

endmodule

// File: rtl/decode_execute_pipe.sv
// rtl/decode_execute_pipe.sv - ID/EX stage: register file, pipeline register, load-use stall, flush
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  squash the execute slot and drop the decode instruction
//   d_valid_i/d_ready_o      decode-side handshake
//   d_pc_i .. d_imm_i        decode instruction fields
//   wb_we_i/wb_addr_i/wb_data_i  writeback port into the register file
//   e_valid_o/e_ready_i      execute-side handshake
//   e_pc_o .. e_rd2_o        registered instruction fields and operands
//   hazard_o                 a load-use bubble is being inserted this cycle
module decode_execute_pipe
    import rv32i_pkg::*;
#(
    parameter int  DPW       = DPW_DEFAULT,
    parameter int  NREG      = 32,
    parameter int  RF_BYPASS = 1,
    localparam int AW        = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush_i,
    input  logic           d_valid_i,
    output logic           d_ready_o,
    input  logic [DPW-1:0] d_pc_i,
    input  logic [AW-1:0]  d_rs1_i,
    input  logic [AW-1:0]  d_rs2_i,
    input  logic [AW-1:0]  d_rd_i,
    input  ctrl_t          d_ctrl_i,
    input  logic [DPW-1:0] d_imm_i,
    input  logic           wb_we_i,
    input  logic [AW-1:0]  wb_addr_i,
    input  logic [DPW-1:0] wb_data_i,
    output logic           e_valid_o,
    input  logic           e_ready_i,
    output logic [DPW-1:0] e_pc_o,
    output logic [AW-1:0]  e_rs1_o,
    output logic [AW-1:0]  e_rs2_o,
    output logic [AW-1:0]  e_rd_o,
    output ctrl_t          e_ctrl_o,
    output logic [DPW-1:0] e_imm_o,
    output logic [DPW-1:0] e_srca_o,
    output logic [DPW-1:0] e_rd2_o,
    output logic           hazard_o
);

    logic [DPW-1:0] rf_a;
    logic [DPW-1:0] rf_b;

    rf_bypass #(
        .DPW    (DPW),
        .NREG   (NREG),
        .BYPASS (RF_BYPASS)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_we_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i),
        .raddr_a_i (d_rs1_i),
        .raddr_b_i (d_rs2_i),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b)
    );

    logic           valid_q, valid_d;
    logic [DPW-1:0] pc_q,    pc_d;
    logic [AW-1:0]  rs1_q,   rs1_d;
    logic [AW-1:0]  rs2_q,   rs2_d;
    logic [AW-1:0]  rd_q,    rd_d;
    ctrl_t          ctrl_q,  ctrl_d;
    logic [DPW-1:0] imm_q,   imm_d;
    logic [DPW-1:0] srca_q,  srca_d;
    logic [DPW-1:0] rd2_q,   rd2_d;

    logic adv;
    logic haz;
    logic wb_live;

    assign adv     = ~valid_q | e_ready_i;
    assign wb_live = wb_we_i & (wb_addr_i != '0);

    // Only a load sitting in execute can stall: its data is not available
    // for forwarding until after the memory stage.
    assign haz = d_valid_i & valid_q & ctrl_q.load & (rd_q != '0) &
                 ((d_ctrl_i.use_rs1 & (d_rs1_i == rd_q)) |
                  (d_ctrl_i.use_rs2 & (d_rs2_i == rd_q)));

    // Flush overrides the stall so the redirected fetch stream never waits.
    assign d_ready_o = ~rst & (flush_i | (adv & ~haz));
    assign hazard_o  = ~rst & ~flush_i & adv & haz;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        imm_d   = imm_q;
        srca_d  = srca_q;
        rd2_d   = rd2_q;
        if (flush_i || (adv && haz)) begin
            // Flushed slot and load-use bubble are both an empty NOP slot.
            valid_d = 1'b0;
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            ctrl_d  = CTRL_NOP;
            imm_d   = '0;
            srca_d  = '0;
            rd2_d   = '0;
        end else if (adv) begin
            valid_d = d_valid_i;
            pc_d    = d_pc_i;
            rs1_d   = d_rs1_i;
            rs2_d   = d_rs2_i;
            rd_d    = d_rd_i;
            ctrl_d  = d_valid_i ? d_ctrl_i : CTRL_NOP;
            imm_d   = d_imm_i;
            srca_d  = rf_a;
            rd2_d   = rf_b;
        end else begin
            // Held instruction: pick up writebacks landing on its sources so
            // the operands are current when execute finally consumes it.
            if (wb_live && (wb_addr_i == rs1_q)) begin
                srca_d = wb_data_i;
            end
            if (wb_live && (wb_addr_i == rs2_q)) begin
                rd2_d = wb_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= CTRL_NOP;
            imm_q   <= '0;
            srca_q  <= '0;
            rd2_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            imm_q   <= imm_d;
            srca_q  <= srca_d;
            rd2_q   <= rd2_d;
        end
    end

    assign e_valid_o = valid_q;
    assign e_pc_o    = pc_q;
    assign e_rs1_o   = rs1_q;
    assign e_rs2_o   = rs2_q;
    assign e_rd_o    = rd_q;
    assign e_ctrl_o  = ctrl_q;
    assign e_imm_o   = imm_q;
    assign e_srca_o  = srca_q;
    assign e_rd2_o   = rd2_q;

endmodule

// File: tb/tb_decode_execute_pipe.sv
// tb/tb_decode_execute_pipe.sv - directed and random checks of decode_execute_pipe against a reference model
module tb_decode_execute_pipe;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, d_valid, e_ready, wb_we;
    logic [31:0] d_pc, d_imm, wb_data;
    logic [4:0]  d_rs1, d_rs2, d_rd, wb_addr;
    ctrl_t       d_ctrl;

    logic        d_ready, hazard, e_valid;
    logic [31:0] e_pc, e_imm, e_srca, e_rd2;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    ctrl_t       e_ctrl;

    logic        d2_ready, hazard2, e2_valid;
    logic [31:0] e2_pc, e2_imm, e2_srca, e2_rd2;
    logic [3:0]  e2_rs1, e2_rs2, e2_rd;
    ctrl_t       e2_ctrl;

    decode_execute_pipe #(.DPW(32), .NREG(32), .RF_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .d_valid_i(d_valid), .d_ready_o(d_ready), .d_pc_i(d_pc),
        .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .d_rd_i(d_rd), .d_ctrl_i(d_ctrl), .d_imm_i(d_imm),
        .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .e_valid_o(e_valid), .e_ready_i(e_ready), .e_pc_o(e_pc),
        .e_rs1_o(e_rs1), .e_rs2_o(e_rs2), .e_rd_o(e_rd), .e_ctrl_o(e_ctrl),
        .e_imm_o(e_imm), .e_srca_o(e_srca), .e_rd2_o(e_rd2), .hazard_o(hazard)
    );

    // RV32E, read-old build sharing the same stimulus (low four address bits).
    decode_execute_pipe #(.DPW(32), .NREG(16), .RF_BYPASS(0)) dut_e (
        .clk(clk), .rst(rst), .flush_i(flush),
        .d_valid_i(d_valid), .d_ready_o(d2_ready), .d_pc_i(d_pc),
        .d_rs1_i(d_rs1[3:0]), .d_rs2_i(d_rs2[3:0]), .d_rd_i(d_rd[3:0]), .d_ctrl_i(d_ctrl), .d_imm_i(d_imm),
        .wb_we_i(wb_we), .wb_addr_i(wb_addr[3:0]), .wb_data_i(wb_data),
        .e_valid_o(e2_valid), .e_ready_i(e_ready), .e_pc_o(e2_pc),
        .e_rs1_o(e2_rs1), .e_rs2_o(e2_rs2), .e_rd_o(e2_rd), .e_ctrl_o(e2_ctrl),
        .e_imm_o(e2_imm), .e_srca_o(e2_srca), .e_rd2_o(e2_rd2), .hazard_o(hazard2)
    );

    int total = 0;
    int bad   = 0;

    // Reference model of the execute slot and the architectural registers.
    logic [31:0] rf_m [32];
    logic        m_valid, m_chk;
    logic [31:0] m_pc, m_imm, m_srca, m_rd2;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    ctrl_t       m_ctrl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdm(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return rf_m[a];
    endfunction

    function automatic ctrl_t mk_ctrl(input logic ld, input logic rw, input logic u1, input logic u2);
        ctrl_t c;
        c = CTRL_NOP;
        c.load = ld;
        c.regwrite = rw;
        c.use_rs1 = u1;
        c.use_rs2 = u2;
        return c;
    endfunction

    task automatic clear_ex();
        m_valid = 1'b0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_ctrl = CTRL_NOP; m_imm = '0; m_srca = '0; m_rd2 = '0;
    endtask

    // One clock: check handshake outputs, advance the model, check the slot.
    task automatic step();
        logic adv, haz, x_ready, x_haz;
        logic [31:0] a, b;
        #1;
        adv = !m_valid || e_ready;
        haz = d_valid && m_valid && m_ctrl.load && (m_rd != 5'd0) &&
              ((d_ctrl.use_rs1 && d_rs1 == m_rd) || (d_ctrl.use_rs2 && d_rs2 == m_rd));
        x_ready = rst ? 1'b0 : (flush ? 1'b1 : (adv && !haz));
        x_haz   = !rst && !flush && adv && haz;
        chk("d_ready", 64'(d_ready), 64'(x_ready));
        chk("hazard", 64'(hazard), 64'(x_haz));
        a = rdm(d_rs1);
        b = rdm(d_rs2);
        if (rst) begin
            clear_ex();
            m_chk = 1'b1;
            for (int i = 0; i < 32; i++) rf_m[i] = '0;
        end else begin
            if (flush) begin
                clear_ex();
                m_chk = 1'b1;
            end else if (adv && haz) begin
                clear_ex();
                m_chk = 1'b0;
            end else if (adv) begin
                m_valid = d_valid; m_pc = d_pc; m_rs1 = d_rs1; m_rs2 = d_rs2; m_rd = d_rd;
                m_ctrl = d_valid ? d_ctrl : CTRL_NOP; m_imm = d_imm; m_srca = a; m_rd2 = b;
                m_chk = 1'b1;
            end else begin
                if (wb_we && wb_addr != 5'd0 && wb_addr == m_rs1) m_srca = wb_data;
                if (wb_we && wb_addr != 5'd0 && wb_addr == m_rs2) m_rd2 = wb_data;
            end
            if (wb_we && wb_addr != 5'd0) rf_m[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
        chk("e_valid", 64'(e_valid), 64'(m_valid));
        chk("e_ctrl", 64'(e_ctrl), 64'(m_ctrl));
        if (m_chk) begin
            chk("e_pc", 64'(e_pc), 64'(m_pc));
            chk("e_rs1", 64'(e_rs1), 64'(m_rs1));
            chk("e_rs2", 64'(e_rs2), 64'(m_rs2));
            chk("e_rd", 64'(e_rd), 64'(m_rd));
            chk("e_imm", 64'(e_imm), 64'(m_imm));
            chk("e_srca", 64'(e_srca), 64'(m_srca));
            chk("e_rd2", 64'(e_rd2), 64'(m_rd2));
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; d_valid = 1'b0; e_ready = 1'b1; wb_we = 1'b0;
        d_pc = '0; d_imm = '0; wb_data = '0; d_rs1 = '0; d_rs2 = '0; d_rd = '0; wb_addr = '0;
        d_ctrl = CTRL_NOP;
        clear_ex();
        m_chk = 1'b1;
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        step();
        step();
        chk("rst_e2_valid", 64'(e2_valid), 64'd0);
        chk("rst_d2_ready", 64'(d2_ready), 64'd0);
        rst = 1'b0;

        // First instruction after reset.
        d_valid = 1'b1; d_rs1 = 5'd5; d_rs2 = 5'd6; d_rd = 5'd1; d_imm = 32'h10; d_pc = 32'h100;
        d_ctrl = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b1);
        step();
        chk("first_valid", 64'(e_valid), 64'd1);
        chk("first_pc", 64'(e_pc), 64'h100);
        chk("first_imm", 64'(e_imm), 64'h10);
        chk("first_srca", 64'(e_srca), 64'd0);

        // Same-cycle writeback to the source being read.
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; d_pc = 32'h104;
        step();
        chk("bypass_on_srca", 64'(e_srca), 64'hDEADBEEF);
        chk("bypass_off_srca", 64'(e2_srca), 64'd0);

        // Writes to x0 are ignored.
        wb_addr = 5'd0; wb_data = 32'h1234; d_rs1 = 5'd0; d_pc = 32'h108;
        step();
        wb_we = 1'b0;
        step();
        chk("x0_srca", 64'(e_srca), 64'd0);
        chk("x0_srca_e", 64'(e2_srca), 64'd0);

        // Load rd=7 followed by a consumer of x7 through rs2.
        d_ctrl = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0); d_rs1 = 5'd1; d_rd = 5'd7; d_pc = 32'h10C;
        step();
        d_ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1); d_rs1 = 5'd2; d_rs2 = 5'd7; d_rd = 5'd3; d_pc = 32'h110;
        #1;
        chk("lu_hazard", 64'(hazard), 64'd1);
        chk("lu_ready", 64'(d_ready), 64'd0);
        step();
        chk("lu_bubble", 64'(e_valid), 64'd0);
        chk("lu_bubble_ctrl", 64'(e_ctrl), 64'(CTRL_NOP));
        #1;
        chk("lu_no_second", 64'(hazard), 64'd0);
        step();
        chk("lu_accept", 64'(e_valid), 64'd1);
        chk("lu_accept_rd", 64'(e_rd), 64'd3);

        // Load to x0 never stalls.
        d_ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0); d_rd = 5'd0; d_pc = 32'h114;
        step();
        d_ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1); d_rs2 = 5'd0; d_rd = 5'd4; d_pc = 32'h118;
        #1;
        chk("rd0_hazard", 64'(hazard), 64'd0);
        chk("rd0_ready", 64'(d_ready), 64'd1);
        step();

        // Held instruction with a writeback to its rs1.
        d_ctrl = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b1); d_rs1 = 5'd9; d_rs2 = 5'd4; d_rd = 5'd8; d_pc = 32'h200;
        step();
        e_ready = 1'b0; d_pc = 32'h300; d_rs1 = 5'd10;
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFE0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_ready", 64'(d_ready), 64'd0);
            step();
            wb_we = 1'b0;
        end
        chk("hold_srca", 64'(e_srca), 64'hCAFE0001);
        chk("hold_pc", 64'(e_pc), 64'h200);
        chk("hold_rs1", 64'(e_rs1), 64'd9);

        // Flush coincident with a load-use hazard.
        e_ready = 1'b1;
        d_ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0); d_rd = 5'd7; d_pc = 32'h400;
        step();
        d_ctrl = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0); d_rs1 = 5'd7; d_pc = 32'h404; flush = 1'b1;
        #1;
        chk("flush_hazard", 64'(hazard), 64'd0);
        chk("flush_ready", 64'(d_ready), 64'd1);
        step();
        flush = 1'b0;
        chk("flush_valid", 64'(e_valid), 64'd0);
        chk("flush_ctrl", 64'(e_ctrl), 64'(CTRL_NOP));

        // RV32E build: fill x1..x15 with 16*i, read back every pair.
        d_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            wb_we = 1'b1; wb_addr = 5'(i); wb_data = 32'(16 * i);
            step();
        end
        wb_we = 1'b0; d_valid = 1'b1; d_ctrl = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                d_rs1 = 5'(i); d_rs2 = 5'(j);
                step();
                chk("e16_srca", 64'(e2_srca), 64'(16 * i));
                chk("e16_rd2", 64'(e2_rd2), 64'(16 * j));
            end
        end

        // Reset in the middle of a hold.
        e_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_e2_valid", 64'(e2_valid), 64'd0);
        chk("midrst_e2_pc", 64'(e2_pc), 64'd0);
        chk("midrst_e2_srca", 64'(e2_srca), 64'd0);
        chk("midrst_e2_ctrl", 64'(e2_ctrl), 64'(CTRL_NOP));
        rst = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 63) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            d_valid = ($urandom_range(0, 3) != 0);
            e_ready = ($urandom_range(0, 3) != 0);
            d_rs1   = 5'($urandom_range(0, 7));
            d_rs2   = 5'($urandom_range(0, 7));
            d_rd    = 5'($urandom_range(0, 7));
            d_pc    = $urandom;
            d_imm   = $urandom;
            d_ctrl.regwrite = 1'($urandom_range(0, 1));
            d_ctrl.load     = 1'($urandom_range(0, 1));
            d_ctrl.memwrite = 1'($urandom_range(0, 1));
            d_ctrl.branch   = 1'($urandom_range(0, 1));
            d_ctrl.alusrc   = 1'($urandom_range(0, 1));
            d_ctrl.use_rs1  = 1'($urandom_range(0, 1));
            d_ctrl.use_rs2  = 1'($urandom_range(0, 1));
            d_ctrl.alu_ctrl = alu_op_t'(4'($urandom_range(0, 9)));
            wb_we   = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
